// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared geometry, op encoding and FSM states for the screen fill engine
package screen_pkg;

  localparam int WORDS_PER_ROW = 32;
  localparam int ROWS          = 256;
  localparam int ADDR_W        = 13;

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_FILL   = 2'd1;
  localparam logic [1:0] OP_INVERT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDW,
    ST_WR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/screen_rect_walker.sv
// rtl/screen_rect_walker.sv - clips the rectangle at start and walks its word addresses row by row
module screen_rect_walker
  import screen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [4:0]        x0,
  input  logic [7:0]        y0,
  input  logic [5:0]        width,
  input  logic [8:0]        height,
  output logic              empty,
  output logic              last,
  output logic [ADDR_W-1:0] address,
  output logic              row_odd
);

  logic [5:0] room_w;
  logic [8:0] room_h;
  logic [5:0] eff_w;
  logic [8:0] eff_h;

  logic [4:0] x_base;
  logic [5:0] col;
  logic [5:0] span;
  logic [7:0] row;
  logic [8:0] rows_left;
  logic [4:0] col_abs;
  logic       row_end;

  // Clipping only ever shrinks the rectangle, so the column never wraps past 31.
  always_comb begin
    room_w = 6'(WORDS_PER_ROW) - {1'b0, x0};
    room_h = 9'(ROWS) - {1'b0, y0};
    eff_w  = (width < room_w) ? width : room_w;
    eff_h  = (height < room_h) ? height : room_h;
  end

  assign empty   = (eff_w == 6'd0) || (eff_h == 9'd0);
  assign row_end = (col == span - 6'd1);
  assign last    = row_end && (rows_left == 9'd1);
  assign col_abs = x_base + col[4:0];
  assign address = {row, col_abs};
  assign row_odd = row[0];

  // Counters park on the last word so an idle engine keeps presenting its final address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_base    <= 5'd0;
      col       <= 6'd0;
      span      <= 6'd0;
      row       <= 8'd0;
      rows_left <= 9'd0;
    end else if (load) begin
      x_base    <= x0;
      col       <= 6'd0;
      span      <= eff_w;
      row       <= y0;
      rows_left <= eff_h;
    end else if (advance && !last) begin
      if (row_end) begin
        col       <= 6'd0;
        row       <= row + 8'd1;
        rows_left <= rows_left - 9'd1;
      end else begin
        col <= col + 6'd1;
      end
    end
  end

endmodule

// File: rtl/screen_fill_engine.sv
// rtl/screen_fill_engine.sv - rectangle clear/fill/invert engine sharing the Screen port with the CPU
// Optional: define SCREEN_FILL_DITHER_EN to invert the FILL pattern on odd rows.
module screen_fill_engine
  import screen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_load,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [15:0]       cpu_in,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [4:0]        x0,
  input  logic [7:0]        y0,
  input  logic [5:0]        width,
  input  logic [8:0]        height,
  input  logic [15:0]       pattern,
  input  logic [15:0]       scr_out,
  output logic [ADDR_W-1:0] scr_address,
  output logic [15:0]       scr_in,
  output logic              scr_load,
  output logic              busy,
  output logic              done
);

`ifdef SCREEN_FILL_DITHER_EN
  localparam logic DITHER_ON = 1'b1;
`else
  localparam logic DITHER_ON = 1'b0;
`endif

  state_t state, state_next;

  logic [1:0]        op_r;
  logic [15:0]       pattern_r;
  logic [15:0]       data_r;
  logic              grant;
  logic              accept;
  logic              capture;
  logic              eng_load;
  logic [15:0]       eng_data;
  logic              walk_adv;
  logic              walk_empty;
  logic              walk_last;
  logic              walk_row_odd;
  logic [ADDR_W-1:0] walk_address;

  assign grant  = !cpu_req;
  assign accept = (state == ST_IDLE) && start;

  screen_rect_walker u_walker (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .advance (walk_adv),
    .x0      (x0),
    .y0      (y0),
    .width   (width),
    .height  (height),
    .empty   (walk_empty),
    .last    (walk_last),
    .address (walk_address),
    .row_odd (walk_row_odd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    eng_load   = 1'b0;
    walk_adv   = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (walk_empty)            state_next = ST_DONE;
          else if (op == OP_INVERT)  state_next = ST_RD;
          else                       state_next = ST_WR;
        end
      end
      ST_RD: begin
        if (grant) state_next = ST_RDW;
      end
      ST_RDW: begin
        // scr_out holds our read now; a CPU access this cycle would replace it next cycle.
        capture    = 1'b1;
        state_next = ST_WR;
      end
      ST_WR: begin
        eng_load = 1'b1;
        if (grant) begin
          walk_adv = 1'b1;
          if (walk_last)              state_next = ST_DONE;
          else if (op_r == OP_INVERT) state_next = ST_RD;
          else                        state_next = ST_WR;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Reserved op 3 is folded into CLEAR when the command is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r      <= OP_CLEAR;
      pattern_r <= 16'h0000;
      data_r    <= 16'h0000;
    end else begin
      if (accept) begin
        op_r      <= ((op == OP_FILL) || (op == OP_INVERT)) ? op : OP_CLEAR;
        pattern_r <= pattern;
      end
      if (capture) data_r <= scr_out;
    end
  end

  always_comb begin
    case (op_r)
      OP_FILL:   eng_data = pattern_r ^ {16{walk_row_odd & DITHER_ON}};
      OP_INVERT: eng_data = ~data_r;
      default:   eng_data = 16'h0000;
    endcase
  end

  assign scr_address = cpu_req ? cpu_address : walk_address;
  assign scr_in      = cpu_req ? cpu_in : eng_data;
  assign scr_load    = cpu_req ? cpu_load : eng_load;

  assign busy = (state == ST_RD) || (state == ST_RDW) || (state == ST_WR);
  assign done = (state == ST_DONE);

endmodule

// File: doc/screen_fill_engine.md
Name: screen_fill_engine

Overview:
- Hardware rectangle clear/fill/invert engine on the CPU side of the Screen framebuffer write port.
- Muxes CPU accesses and its own accesses onto the Screen port (address/in/load, read data returned on out).
- Frees the Hack CPU from ~8192 word writes per full-screen clear.
- Works in 16-pixel word granularity on the 512x256 (32 words x 256 rows) framebuffer.

Parameters:
WORDS_PER_ROW, 32, words per scanline (512/16)
ROWS, 256, scanlines
ADDR_W, 13, framebuffer word address width

Ports:
clk  in  1  system clock (same clock as Screen port)
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU accesses Screen this cycle (read or write)
cpu_load  in  1  CPU write strobe (meaningful when cpu_req=1)
cpu_address  in  13  CPU word address
cpu_in  in  16  CPU write data
start  in  1  one-cycle command strobe
op  in  2  0=CLEAR, 1=FILL, 2=INVERT, 3=reserved (treated as CLEAR)
x0  in  5  left word column 0..31
y0  in  8  top row 0..255
width  in  6  words per row 0..63 (clipped)
height  in  9  rows 0..511 (clipped)
pattern  in  16  FILL data word
scr_out  in  16  Screen read data (registered, valid the cycle after a read)
scr_address  out  13  to Screen address
scr_in  out  16  to Screen in
scr_load  out  1  to Screen load
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE, busy=0, done=0, engine write strobe 0, counters 0. Reset mid-operation aborts immediately; words already written stay written.
- Port mux (combinational): cpu_req=1 -> scr_* = cpu_address/cpu_in/cpu_load (CPU always wins, engine stalls that cycle). Otherwise scr_* driven by engine; idle engine drives scr_load=0 and holds its last address.
- Command latch: start sampled only in IDLE; ignored while busy (no queueing).
- Clipping at start: eff_w = min(width, 32-x0); eff_h = min(height, 256-y0). eff_w=0 or eff_h=0 -> DONE next cycle with no writes.
- Address = row*32 + col. Columns run x0..x0+eff_w-1, then next row. No horizontal wrap.
- States:
  - IDLE: on start -> WR (CLEAR/FILL) or RD (INVERT); busy=1 from next cycle.
  - RD: drives read (scr_load=0) at current address. If granted (cpu_req=0) -> RDW; else stay.
  - RDW: unconditionally captures scr_out into data register (capture independent of grant, since a CPU access this cycle would overwrite out) -> WR.
  - WR: drives scr_load=1 with data: CLEAR=0x0000, FILL=pattern, INVERT=~captured. If granted: advance col/row; last word -> DONE, else stay WR (fill) or RD (invert). Not granted: hold.
  - DONE: done=1 for one cycle, busy=0 from this cycle -> IDLE.
- Latency with no CPU traffic, start in cycle 0: CLEAR/FILL writes in cycles 1..N (N=eff_w*eff_h), done in cycle N+1. INVERT uses 3 cycles per word; done in cycle 3N+1.
- A CPU write to a word between its RD and WR is lost to the engine's write-back; software must not touch the active rectangle while busy.

Optional Feature:
- Macro SCREEN_FILL_DITHER_EN.
- Defined: FILL inverts pattern on odd absolute rows (y odd), producing checkerboard/dither fills.
- Undefined: FILL writes pattern unchanged on every row.
- CLEAR/INVERT unaffected either way.

Decomposition:
- Shared package (screen_pkg): WORDS_PER_ROW, ROWS, ADDR_W, op encoding constants (OP_CLEAR, OP_FILL, OP_INVERT), state enum.
- One natural sub-module: screen_rect_walker (col/row counters, clip computation, address generation, last-word flag).
- Mux and FSM stay in the top.

Test Plan:
- Full CLEAR (x0=0,y0=0,w=32,h=256), cpu_req=0 -> 8192 writes of 0x0000 at addresses 0..8191 consecutive; done pulse in cycle 8193; busy low afterwards.
- FILL x0=30,y0=254,w=8,h=8,pattern=0xA5A5 -> clipped to 2x2; writes only 8158,8159,8190,8191; done in cycle 5.
- INVERT 1x1 at address 0 preloaded 0x00FF, cpu_req forced high in the RDW cycle and first WR cycle -> 0xFF00 written; CPU read data unaffected; done delayed by 1 stall cycle.
- width=0 or height=0 start -> no scr_load from engine; done in cycle 1.
- start pulsed again while busy, and reset asserted mid-FILL -> second start ignored; on reset scr_load=0, busy=0 immediately; new start accepted afterwards.
- With SCREEN_FILL_DITHER_EN, FILL 1x2 at (0,0), pattern 0x00FF -> addr 0 = 0x00FF, addr 32 = 0xFF00.
